hazard_ctrl: RTL and testbench

//  Pipeline control unit that drives the hold/flush inputs of the IF/ID, ID/EX
//  and EX/MEM pipeline registers and the PC write-enable.

---
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use stall, branch/jump flush, multi-cycle multiply and memory-wait stalls.
// Latency: outputs are combinational from state/cnt/inputs; the state reacts on the next rising edge.
// Backpressure: memory wait freezes every stage; a multiply freezes the front end and bubbles EX/MEM.
module hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rt_i,
    input  logic       id_branch_taken_i,
    input  logic       id_jump_i,
    input  logic       id_mul_i,
    input  logic       mem_req_i,
    input  logic       mem_ack_i,
    output logic       pc_hold_o,
    output logic       ifid_hold_o,
    output logic       ifid_flush_o,
    output logic       idex_hold_o,
    output logic       idex_bubble_o,
    output logic       exmem_hold_o,
    output logic       exmem_bubble_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MUL  = 2'd1,
        MEMW = 2'd2
    } state_t;

    // The counter is loaded with MUL_LAT-1 so that the MUL state lasts
    // MUL_LAT-1 cycles after the cycle the multiply sat in ID.
    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic load_use;
    logic memstall;
    logic redirect;

    assign load_use = ex_memread_i && (ex_rt_i != 5'd0) &&
                      ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
    assign memstall = mem_req_i && !mem_ack_i;
    assign redirect = id_branch_taken_i || id_jump_i;

    // State and stall counter sequencing.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= RUN;
            cnt   <= CNT_ZERO;
        end else begin
            case (state)
                RUN: begin
                    if (memstall) begin
                        state <= MEMW;
                    end else if (!load_use && id_mul_i) begin
                        // A taken branch alongside the multiply still lets it start.
                        cnt   <= MUL_INIT;
                        state <= MUL;
                    end
                end
                MUL: begin
                    if (memstall) begin
                        // Memory wait takes over; the remaining multiply count is kept.
                        state <= MEMW;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            state <= RUN;
                        end
                    end
                end
                MEMW: begin
                    if (mem_ack_i) begin
                        state <= (cnt != CNT_ZERO) ? MUL : RUN;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= CNT_ZERO;
                end
            endcase
        end
    end

    // Hold/flush/bubble decode; everything is forced low while reset is asserted.
    always_comb begin
        pc_hold_o      = 1'b0;
        ifid_hold_o    = 1'b0;
        ifid_flush_o   = 1'b0;
        idex_hold_o    = 1'b0;
        idex_bubble_o  = 1'b0;
        exmem_hold_o   = 1'b0;
        exmem_bubble_o = 1'b0;
        if (rst_i) begin
            case (state)
                RUN: begin
                    if (memstall) begin
                        pc_hold_o    = 1'b1;
                        ifid_hold_o  = 1'b1;
                        idex_hold_o  = 1'b1;
                        exmem_hold_o = 1'b1;
                    end else if (load_use) begin
                        pc_hold_o     = 1'b1;
                        ifid_hold_o   = 1'b1;
                        idex_bubble_o = 1'b1;
                    end else if (redirect) begin
                        ifid_flush_o = 1'b1;
                    end
                end
                MUL: begin
                    pc_hold_o   = 1'b1;
                    ifid_hold_o = 1'b1;
                    idex_hold_o = 1'b1;
                    if (memstall) begin
                        exmem_hold_o = 1'b1;
                    end else begin
                        exmem_bubble_o = 1'b1;
                    end
                end
                MEMW: begin
                    // Holds release in the same cycle the memory acknowledges.
                    if (!mem_ack_i) begin
                        pc_hold_o    = 1'b1;
                        ifid_hold_o  = 1'b1;
                        idex_hold_o  = 1'b1;
                        exmem_hold_o = 1'b1;
                    end
                end
                default: begin
                    pc_hold_o = 1'b0;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-scenario tables of inputs and expected outputs.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// No backpressure; each step is exactly one clock.
module tb_hazard_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] id_rs_i;
    logic [4:0] id_rt_i;
    logic       ex_memread_i;
    logic [4:0] ex_rt_i;
    logic       id_branch_taken_i;
    logic       id_jump_i;
    logic       id_mul_i;
    logic       mem_req_i;
    logic       mem_ack_i;
    logic       pc_hold_o;
    logic       ifid_hold_o;
    logic       ifid_flush_o;
    logic       idex_hold_o;
    logic       idex_bubble_o;
    logic       exmem_hold_o;
    logic       exmem_bubble_o;
    logic [1:0] state_o;

    int n_cmp = 0;
    int n_err = 0;

    // Output vector order: pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold, exmem_bubble
    logic [6:0] outs;
    assign outs = {pc_hold_o, ifid_hold_o, ifid_flush_o, idex_hold_o,
                   idex_bubble_o, exmem_hold_o, exmem_bubble_o};

    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_LU   = 7'b1100100;
    localparam logic [6:0] O_ALL  = 7'b1101010;
    localparam logic [6:0] O_MUL  = 7'b1101001;
    localparam logic [6:0] O_FL   = 7'b0010000;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       mr;
        logic [4:0] ert;
        logic       br;
        logic       jp;
        logic       ml;
        logic       rq;
        logic       ak;
        logic [6:0] eo;
        logic [1:0] es;
    } step_t;

    hazard_ctrl #(.MUL_LAT(4), .CNT_W(3)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .id_rs_i           (id_rs_i),
        .id_rt_i           (id_rt_i),
        .ex_memread_i      (ex_memread_i),
        .ex_rt_i           (ex_rt_i),
        .id_branch_taken_i (id_branch_taken_i),
        .id_jump_i         (id_jump_i),
        .id_mul_i          (id_mul_i),
        .mem_req_i         (mem_req_i),
        .mem_ack_i         (mem_ack_i),
        .pc_hold_o         (pc_hold_o),
        .ifid_hold_o       (ifid_hold_o),
        .ifid_flush_o      (ifid_flush_o),
        .idex_hold_o       (idex_hold_o),
        .idex_bubble_o     (idex_bubble_o),
        .exmem_hold_o      (exmem_hold_o),
        .exmem_bubble_o    (exmem_bubble_o),
        .state_o           (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic apply(input step_t s);
        id_rs_i           = s.rs;
        id_rt_i           = s.rt;
        ex_memread_i      = s.mr;
        ex_rt_i           = s.ert;
        id_branch_taken_i = s.br;
        id_jump_i         = s.jp;
        id_mul_i          = s.ml;
        mem_req_i         = s.rq;
        mem_ack_i         = s.ak;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        step_t s;
        rst_i = 1'b0;
        s = '{rs:5'd5, rt:5'd0, mr:1'b1, ert:5'd5, br:1'b1, jp:1'b1, ml:1'b1, rq:1'b1, ak:1'b0,
              eo:O_NONE, es:2'd0};
        apply(s);
        @(negedge clk_i);
        n_cmp++;
        if (outs !== O_NONE || state_o !== 2'd0) begin
            n_err++;
            $display("FAIL reset_hold: outs=%b state=%0d, expected outs=%b state=0", outs, state_o, O_NONE);
        end
        next_cycle();
        rst_i = 1'b1;
        s = '0;
        apply(s);
        @(negedge clk_i);
        n_cmp++;
        if (outs !== O_NONE || state_o !== 2'd0) begin
            n_err++;
            $display("FAIL reset_release: outs=%b state=%0d, expected outs=%b state=0", outs, state_o, O_NONE);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        step_t v[6];
        v = '{
            '{5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_LU,   2'd0},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, 2'd0},
            '{5'd3, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_LU,   2'd0},
            '{5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, 2'd0},
            '{5'd6, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, 2'd0},
            '{5'd0, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, 2'd0}
        };
        for (int i = 0; i < 6; i++) begin
            apply(v[i]);
            @(negedge clk_i);
            n_cmp++;
            if (outs !== v[i].eo || state_o !== v[i].es) begin
                n_err++;
                $display("FAIL load_use[%0d]: outs=%b state=%0d, expected outs=%b state=%0d",
                         i, outs, state_o, v[i].eo, v[i].es);
            end
            next_cycle();
        end
    endtask

    task automatic test_branch();
        step_t v[6];
        v = '{
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_FL,   2'd0},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, 2'd0},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_FL,   2'd0},
            '{5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_LU,   2'd0},
            '{5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_LU,   2'd0},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, 2'd0}
        };
        for (int i = 0; i < 6; i++) begin
            apply(v[i]);
            @(negedge clk_i);
            n_cmp++;
            if (outs !== v[i].eo || state_o !== v[i].es) begin
                n_err++;
                $display("FAIL branch[%0d]: outs=%b state=%0d, expected outs=%b state=%0d",
                         i, outs, state_o, v[i].eo, v[i].es);
            end
            next_cycle();
        end
    endtask

    task automatic test_mul();
        step_t v[10];
        v = '{
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_NONE, 2'd0},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_MUL,  2'd1},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_MUL,  2'd1},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_MUL,  2'd1},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, 2'd0},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_FL,   2'd0},
            '{5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_MUL,  2'd1},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_MUL,  2'd1},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_MUL,  2'd1},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, 2'd0}
        };
        for (int i = 0; i < 10; i++) begin
            apply(v[i]);
            @(negedge clk_i);
            n_cmp++;
            if (outs !== v[i].eo || state_o !== v[i].es) begin
                n_err++;
                $display("FAIL mul[%0d]: outs=%b state=%0d, expected outs=%b state=%0d",
                         i, outs, state_o, v[i].eo, v[i].es);
            end
            next_cycle();
        end
    endtask

    task automatic test_memw();
        step_t v[10];
        v = '{
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_ALL,  2'd0},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_ALL,  2'd2},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, O_ALL,  2'd2},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_NONE, 2'd2},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, 2'd0},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_NONE, 2'd0},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, 2'd0},
            '{5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, O_ALL,  2'd0},
            '{5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, O_NONE, 2'd2},
            '{5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_LU,   2'd0}
        };
        for (int i = 0; i < 10; i++) begin
            apply(v[i]);
            @(negedge clk_i);
            n_cmp++;
            if (outs !== v[i].eo || state_o !== v[i].es) begin
                n_err++;
                $display("FAIL memw[%0d]: outs=%b state=%0d, expected outs=%b state=%0d",
                         i, outs, state_o, v[i].eo, v[i].es);
            end
            next_cycle();
        end
    endtask

    task automatic test_mul_memw();
        step_t v[8];
        v = '{
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_NONE, 2'd0},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_MUL,  2'd1},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_ALL,  2'd1},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_ALL,  2'd2},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_NONE, 2'd2},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_MUL,  2'd1},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_MUL,  2'd1},
            '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, 2'd0}
        };
        for (int i = 0; i < 8; i++) begin
            apply(v[i]);
            @(negedge clk_i);
            n_cmp++;
            if (outs !== v[i].eo || state_o !== v[i].es) begin
                n_err++;
                $display("FAIL mul_memw[%0d]: outs=%b state=%0d, expected outs=%b state=%0d",
                         i, outs, state_o, v[i].eo, v[i].es);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_mul();
        step_t s;
        s = '0;
        s.ml = 1'b1;
        apply(s);
        @(negedge clk_i);
        n_cmp++;
        if (outs !== O_NONE || state_o !== 2'd0) begin
            n_err++;
            $display("FAIL rst_mul_start: outs=%b state=%0d, expected outs=%b state=0", outs, state_o, O_NONE);
        end
        next_cycle();
        s = '0;
        apply(s);
        @(negedge clk_i);
        n_cmp++;
        if (outs !== O_MUL || state_o !== 2'd1) begin
            n_err++;
            $display("FAIL rst_mul_active: outs=%b state=%0d, expected outs=%b state=1", outs, state_o, O_MUL);
        end
        next_cycle();
        // Still in MUL here; reset must clear outputs without waiting for a clock edge.
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if (outs !== O_NONE || state_o !== 2'd0) begin
            n_err++;
            $display("FAIL rst_mul_async: outs=%b state=%0d, expected outs=%b state=0", outs, state_o, O_NONE);
        end
        next_cycle();
        rst_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            n_cmp++;
            if (outs !== O_NONE || state_o !== 2'd0) begin
                n_err++;
                $display("FAIL rst_mul_after[%0d]: outs=%b state=%0d, expected outs=%b state=0",
                         i, outs, state_o, O_NONE);
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mul();
        test_memw();
        test_mul_memw();
        test_reset_mid_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
